// File: rtl/sn74hc595_trio_seg8_receiver.sv
// Receive side of the three-digit SN74HC595 display bus: oversamples clk_serial/data/load,
// rebuilds the 24-bit frame and decodes the common-anode codes back to BCD and point position.
module sn74hc595_trio_seg8_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_serial,
  input  logic        data,
  input  logic        load,
  output logic [23:0] frame,
  output logic [3:0]  num0,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [1:0]  point_pos,
  output logic        valid,
  output logic        code_err,
  output logic        frame_err
);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic [SYNC_STAGES-1:0] load_sync_r;
  logic                   clk_dly_r;
  logic                   load_dly_r;

  logic [23:0] sr_r;
  logic [4:0]  cnt_r;

  logic        shift_s;
  logic        load_s;
  logic        good_s;
  logic [23:0] sr_next_s;
  logic [4:0]  cnt_next_s;
  logic [3:0]  dig0_s;
  logic [3:0]  dig1_s;
  logic [3:0]  dig2_s;
  logic [2:0]  lit_s;
  logic [1:0]  pos_s;
  logic        bad_code_s;

  // Segment bits are inverted first, so the table is in lit-segment (g..a) form.
  function automatic logic [3:0] seg_to_bcd(input logic [7:0] code);
    logic [6:0] seg;
    seg = ~code[6:0];
    case (seg)
      7'h3F:   return 4'd0;
      7'h06:   return 4'd1;
      7'h5B:   return 4'd2;
      7'h4F:   return 4'd3;
      7'h66:   return 4'd4;
      7'h6D:   return 4'd5;
      7'h7D:   return 4'd6;
      7'h07:   return 4'd7;
      7'h7F:   return 4'd8;
      7'h6F:   return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [1:0] point_index(input logic [2:0] lit);
    if (lit[0]) begin
      return 2'd1;
    end else if (lit[1]) begin
      return 2'd2;
    end else if (lit[2]) begin
      return 2'd3;
    end else begin
      return 2'd0;
    end
  endfunction

  function automatic logic multi_lit(input logic [2:0] lit);
    return (lit & (lit - 3'd1)) != 3'd0;
  endfunction

  // Input synchronisers plus one delay flop for edge detection on clk_serial and load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= '0;
      data_sync_r <= '0;
      load_sync_r <= '0;
      clk_dly_r   <= 1'b0;
      load_dly_r  <= 1'b0;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], clk_serial};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], data};
      load_sync_r <= {load_sync_r[SYNC_STAGES-2:0], load};
      clk_dly_r   <= clk_sync_r[SYNC_STAGES-1];
      load_dly_r  <= load_sync_r[SYNC_STAGES-1];
    end
  end

  assign shift_s = clk_sync_r[SYNC_STAGES-1] & ~clk_dly_r;
  assign load_s  = load_sync_r[SYNC_STAGES-1] & ~load_dly_r;

  // A shift coinciding with a load is applied first, so the latch sees the post-shift frame.
  always_comb begin
    sr_next_s  = sr_r;
    cnt_next_s = cnt_r;
    if (shift_s) begin
      sr_next_s = {sr_r[22:0], data_sync_r[SYNC_STAGES-1]};
      if (cnt_r != 5'd31) begin
        cnt_next_s = cnt_r + 5'd1;
      end else begin
        cnt_next_s = cnt_r;
      end
    end else begin
      sr_next_s  = sr_r;
      cnt_next_s = cnt_r;
    end
  end

  always_comb begin
    dig0_s     = seg_to_bcd(sr_next_s[7:0]);
    dig1_s     = seg_to_bcd(sr_next_s[15:8]);
    dig2_s     = seg_to_bcd(sr_next_s[23:16]);
    lit_s      = {~sr_next_s[23], ~sr_next_s[15], ~sr_next_s[7]};
    pos_s      = point_index(lit_s);
    bad_code_s = (dig0_s == 4'hF) | (dig1_s == 4'hF) | (dig2_s == 4'hF) | multi_lit(lit_s);
    good_s     = load_s & (cnt_next_s == 5'd24);
  end

  // Shift register and bit counter; the count restarts on every load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r  <= 24'h0;
      cnt_r <= 5'd0;
    end else begin
      sr_r  <= sr_next_s;
      cnt_r <= load_s ? 5'd0 : cnt_next_s;
    end
  end

  // Output latch: status updates on every load, decoded fields only on a 24-bit load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame     <= 24'h0;
      num0      <= 4'h0;
      num1      <= 4'h0;
      num2      <= 4'h0;
      point_pos <= 2'd0;
      valid     <= 1'b0;
      code_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= load_s;
      if (load_s) begin
        frame_err <= ~good_s;
      end
      if (good_s) begin
        frame     <= sr_next_s;
        num0      <= dig0_s;
        num1      <= dig1_s;
        num2      <= dig2_s;
        point_pos <= pos_s;
        code_err  <= bad_code_s;
      end
    end
  end

endmodule

// File: tb/tb_sn74hc595_trio_seg8_receiver.sv
// Directed bench for the 595 display-bus receiver: drives serial frames and checks the decode.
module tb_sn74hc595_trio_seg8_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_serial = 1'b0;
  logic        data = 1'b0;
  logic        load = 1'b0;
  logic [23:0] frame;
  logic [3:0]  num0;
  logic [3:0]  num1;
  logic [3:0]  num2;
  logic [1:0]  point_pos;
  logic        valid;
  logic        code_err;
  logic        frame_err;

  int n_checks = 0;
  int n_bad    = 0;
  int vcount;

  sn74hc595_trio_seg8_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_serial(clk_serial), .data(data), .load(load),
    .frame(frame), .num0(num0), .num1(num1), .num2(num2), .point_pos(point_pos),
    .valid(valid), .code_err(code_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int ph);
    data = b;
    repeat (ph) @(negedge clk);
    clk_serial = 1'b1;
    repeat (ph) @(negedge clk);
    clk_serial = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n, input int ph);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], ph);
  endtask

  // Raises load (optionally with a clk_serial rise) and counts valid pulses in a bounded window.
  task automatic do_load(input logic with_shift);
    vcount = 0;
    @(negedge clk);
    load = 1'b1;
    if (with_shift) clk_serial = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    @(negedge clk);
    load = 1'b0;
    clk_serial = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
  endtask

  task automatic check_decode(input string tag, input logic [23:0] f, input logic [3:0] n2,
                              input logic [3:0] n1, input logic [3:0] n0, input logic [1:0] pp,
                              input logic ce, input logic fe);
    check_val({tag, "_frame"}, {8'h0, frame}, {8'h0, f});
    check_val({tag, "_num2"}, {28'h0, num2}, {28'h0, n2});
    check_val({tag, "_num1"}, {28'h0, num1}, {28'h0, n1});
    check_val({tag, "_num0"}, {28'h0, num0}, {28'h0, n0});
    check_val({tag, "_point"}, {30'h0, point_pos}, {30'h0, pp});
    check_val({tag, "_code_err"}, {31'h0, code_err}, {31'h0, ce});
    check_val({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, fe});
    check_val({tag, "_valid_pulses"}, vcount, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle bus: nothing moves, valid never fires.
    vcount = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    check_val("idle_valid", vcount, 32'd0);
    check_val("idle_frame", {8'h0, frame}, 32'h0);
    check_val("idle_nums", {20'h0, num2, num1, num0}, 32'h0);
    check_val("idle_status", {28'h0, point_pos, code_err, frame_err}, 32'h0);

    send_bits(24'h9979B0, 24, 250);
    do_load(1'b0);
    check_decode("f1", 24'h9979B0, 4'd4, 4'd1, 4'd3, 2'd2, 1'b0, 1'b0);

    send_bits(24'h000000, 24, 6);
    do_load(1'b0);
    check_decode("all8", 24'h000000, 4'd8, 4'd8, 4'd8, 2'd1, 1'b1, 1'b0);

    send_bits(24'h9979B0, 24, 6);
    do_load(1'b0);
    check_decode("f1b", 24'h9979B0, 4'd4, 4'd1, 4'd3, 2'd2, 1'b0, 1'b0);
    send_bits(24'hFFFFFF, 23, 6);
    do_load(1'b0);
    check_decode("short23", 24'h9979B0, 4'd4, 4'd1, 4'd3, 2'd2, 1'b0, 1'b1);

    send_bits(24'hFFC0F9, 24, 6);
    do_load(1'b0);
    check_decode("blank2", 24'hFFC0F9, 4'hF, 4'd0, 4'd1, 2'd0, 1'b1, 1'b0);

    // Reset in the middle of a frame, then a clean frame.
    send_bits(24'hABCDEF, 12, 6);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_frame", {8'h0, frame}, 32'h0);
    check_val("rst_status", {27'h0, valid, point_pos, code_err, frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(24'h9979B0, 24, 6);
    do_load(1'b0);
    check_decode("post_rst", 24'h9979B0, 4'd4, 4'd1, 4'd3, 2'd2, 1'b0, 1'b0);

    // Last bit's clk_serial rise lands in the same clk as the load rise.
    send_bits(24'hC0F9A4 >> 1, 23, 6);
    data = 1'b0;
    repeat (6) @(negedge clk);
    do_load(1'b1);
    check_decode("aligned", 24'hC0F9A4, 4'd0, 4'd1, 4'd2, 2'd0, 1'b0, 1'b0);

    // Load with no shifts since the previous one.
    do_load(1'b0);
    check_decode("empty", 24'hC0F9A4, 4'd0, 4'd1, 4'd2, 2'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
